display_scan: RTL and testbench
===============================

# display_scan

Time-multiplexed driver for the six-digit common-anode 7-segment display of the RC resistance meter. It sits directly downstream of the measurement controller and its BCD converter, and takes a 24-bit, six-digit BCD result with a one-cycle load strobe. The result is double-buffered so the display only changes at frame boundaries. The block scans one digit at a time with an anti-ghosting blank interval and drives active-low segment and anode lines.

## Interface
- CLK_HZ, 50_000_000, system clock frequency
- REFRESH_HZ, 1000, per-digit slot rate; DIV = CLK_HZ/REFRESH_HZ cycles per digit slot
- BLANK_CYC, 64, cycles at the start of each slot with all anodes off; must satisfy BLANK_CYC < DIV

- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- bcd_in  in  24  six BCD digits; [23:20] = digit1 (leftmost, most significant), [3:0] = digit6
- load  in  1  one-cycle strobe; capture bcd_in and overflow_in
- overflow_in  in  1  measurement overflowed; sampled with load
- seg_out  out  8  active-low segments, bit7 = a … bit1 = g, bit0 = dp
- an_out  out  6  active-low anodes, bit0 = digit1
- frame_done  out  1  one-cycle pulse at the end of each complete six-digit frame

## Operation
- Registers:
  - shadow (24b digits + 1b overflow) plus pending flag
  - active (24b + 1b), which is the currently displayed value
  - prescaler 0..DIV-1
  - index 0..5
- load: shadow <= {overflow_in, bcd_in}; pending <= 1. A later load while pending overwrites the shadow (latest wins).
- Slot sequence: the prescaler counts every cycle and wraps at DIV-1. On wrap, index advances 0→1→…→5→0.
- Frame boundary = wrap with index == 5. At the boundary:
  - frame_done pulses.
  - If pending: active <= shadow and pending <= 0.
  - If load is asserted in the same cycle, active takes {overflow_in, bcd_in} directly and pending stays 0.
- Output per slot:
  - While prescaler < BLANK_CYC: an_out = 6'h3F and seg_out = 8'hFF.
  - Otherwise: an_out has only bit[index] low, and seg_out = decode(active digit[index]).
- Decode:
  - 0–9: standard patterns (e.g. 0 = 8'h03, 1 = 8'h9F, 8 = 8'h01), dp always off.
  - 0xA–0xF: dash, 8'hFD.
  - active overflow = 1: every digit shows dash.

## Timing
- seg_out, an_out and frame_done are registered: they reflect the prescaler/index state of the previous cycle (1-cycle latency).
- Reset values:
  - Outputs: seg_out = 8'hFF, an_out = 6'h3F, frame_done = 0.
  - State: prescaler = 0, index = 0, shadow = active = 0, pending = 0.
- Frame length is 6·DIV cycles.
- Latency from load to first visible digit: up to 6·DIV + BLANK_CYC + 1 cycles.
- Reset mid-frame aborts the scan immediately. Any pending value is discarded.
- A load during reset is ignored.

## Configuration
- DISPLAY_SCAN_LZB_EN defined: leading-zero blanking.
  - Digits 1–5 that are 0 and have only zeros to their left output 8'hFF while their anode is still driven.
  - digit6 is never blanked.
  - Overflow dashes are never blanked.
- Undefined: all six digits are always displayed, including leading zeros.

## Structure
- Shared package display_pkg holds:
  - segment pattern constants SEG_DIGIT[0:9], SEG_BLANK = 8'hFF, SEG_DASH = 8'hFD
  - NUM_DIGITS = 6
- One sub-module, seg_decode: a combinational 4-bit digit plus dash flag in, 8-bit active-low pattern out. It is instantiated once and muxed by index, not six times.

## Test plan
All scenarios use CLK_HZ = 1000, REFRESH_HZ = 100, BLANK_CYC = 2, so DIV = 10.
- Reset: hold reset for 3 cycles → seg_out = 8'hFF, an_out = 6'h3F, frame_done = 0 throughout. After release the display shows 000000, or "     0" with LZB.
- Scan order: load 24'h123456 → after the next frame boundary, slots show 1, 2, …, 6 with an_out = 6'h3E, 6'h3D, …, 6'h1F. Each slot has 2 blank cycles then 8 lit cycles. frame_done pulses every 60 cycles.
- Double buffer: load 24'h111111 at frame cycle 5, then 24'h222222 at cycle 20 → only 222222 is ever displayed, starting in the frame after the boundary. 111111 never appears.
- Load at boundary: assert load with 24'h000789 exactly on the index-5 wrap cycle → the next frame shows 000789, or "   789" with LZB.
- Overflow and invalid BCD:
  - load with overflow_in = 1 → all six slots show 8'hFD.
  - load 24'h12A456 with overflow_in = 0 → the third slot shows 8'hFD and the others show their digits.
- Reset mid-frame: assert reset at index 3, cycle 34, with pending set → next cycle outputs are idle, and after release the scan restarts at index 0 with active = 0.

Source files
------------

// File: rtl/display_pkg.sv
// ============================================================================
//  display_pkg
//  Shared segment patterns, digit geometry and the display value record.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package display_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int DIGIT_W    = 4;
   localparam int IDX_W      = 3;

   // Active-low, bit7 = a ... bit1 = g, bit0 = dp
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hFD;
   localparam logic [7:0] SEG_DIGIT [0:9] = '{
      8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
      8'h49, 8'h41, 8'h1F, 8'h01, 8'h09
   };

   typedef struct packed {
      logic                            ovf;
      logic [NUM_DIGITS*DIGIT_W-1:0]   digits;
   } disp_val_t;

   // Digit 0 is the leftmost (most significant) nibble.
   function automatic logic [DIGIT_W-1:0] digit_at(
      input logic [NUM_DIGITS*DIGIT_W-1:0] digits,
      input logic [IDX_W-1:0]              idx
   );
      logic [DIGIT_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) r = digits[DIGIT_W*(NUM_DIGITS-1-i) +: DIGIT_W];
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg_decode.sv
// ============================================================================
//  seg_decode
//  BCD digit to active-low 7-segment pattern; non-decimal codes show a dash.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module seg_decode
   import display_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   input  logic               dash_i,
   output logic [7:0]         seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      if (!dash_i) begin
         for (int i = 0; i < 10; i++) begin
            if (digit_i == DIGIT_W'(i)) seg_o = SEG_DIGIT[i];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/display_scan.sv
// ============================================================================
//  display_scan
//  Six-digit multiplexed 7-segment driver with double-buffered BCD input,
//  anti-ghosting blank interval and active-low segment/anode outputs.
//  Optional: define DISPLAY_SCAN_LZB_EN for leading-zero blanking.
//  BLANK_CYC must be smaller than CLK_HZ/REFRESH_HZ.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module display_scan
   import display_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int REFRESH_HZ = 1000,
   parameter int BLANK_CYC  = 64
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] bcd_in,
   input  logic                          load,
   input  logic                          overflow_in,
   output logic [7:0]                    seg_out,
   output logic [NUM_DIGITS-1:0]         an_out,
   output logic                          frame_done
);

   localparam int DIV   = CLK_HZ / REFRESH_HZ;
   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(DIV - 1);
   localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

   logic [PRE_W-1:0]      prescaler_q, prescaler_d;
   logic [IDX_W-1:0]      index_q,     index_d;
   disp_val_t             shadow_q,    shadow_d;
   disp_val_t             active_q,    active_d;
   logic                  pending_q,   pending_d;
   logic [7:0]            seg_q,       seg_d;
   logic [NUM_DIGITS-1:0] an_q,        an_d;
   logic                  fd_q,        fd_d;

   logic                  wrap;
   logic                  boundary;
   logic                  in_blank;
   logic                  lz_blank;
   logic [DIGIT_W-1:0]    cur_digit;
   logic [7:0]            dec_seg;
   disp_val_t             load_val;

   assign wrap      = (prescaler_q == PRE_MAX);
   assign boundary  = wrap && (index_q == IDX_MAX);
   assign in_blank  = (prescaler_q < BLANK_END);
   assign cur_digit = digit_at(active_q.digits, index_q);
   assign load_val  = '{ovf: overflow_in, digits: bcd_in};

   seg_decode u_seg_decode (
      .digit_i (cur_digit),
      .dash_i  (active_q.ovf),
      .seg_o   (dec_seg)
   );

`ifdef DISPLAY_SCAN_LZB_EN
   // A digit is blanked while it and everything to its left is zero; the
   // rightmost digit is excluded so a zero reading still shows "0".
   always_comb begin
      logic lz_run;
      lz_run   = 1'b1;
      lz_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS-1; i++) begin
         lz_run = lz_run && (active_q.digits[DIGIT_W*(NUM_DIGITS-1-i) +: DIGIT_W] == '0);
         if (index_q == IDX_W'(i)) lz_blank = lz_run && !active_q.ovf;
      end
   end
`else
   assign lz_blank = 1'b0;
`endif

   always_comb begin
      prescaler_d = wrap ? '0 : prescaler_q + PRE_W'(1);
      index_d     = index_q;
      if (wrap) index_d = (index_q == IDX_MAX) ? '0 : index_q + IDX_W'(1);

      shadow_d  = shadow_q;
      pending_d = pending_q;
      active_d  = active_q;
      if (load) begin
         shadow_d  = load_val;
         pending_d = 1'b1;
      end
      // A load coinciding with the frame boundary bypasses the shadow.
      if (boundary) begin
         if (load) begin
            active_d  = load_val;
            pending_d = 1'b0;
         end else if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
         end
      end

      if (in_blank) begin
         an_d  = '1;
         seg_d = SEG_BLANK;
      end else begin
         an_d  = ~(NUM_DIGITS'(1) << index_q);
         seg_d = lz_blank ? SEG_BLANK : dec_seg;
      end
      fd_d = boundary;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler_q <= '0;
         index_q     <= '0;
         shadow_q    <= '0;
         active_q    <= '0;
         pending_q   <= 1'b0;
         seg_q       <= SEG_BLANK;
         an_q        <= '1;
         fd_q        <= 1'b0;
      end else begin
         prescaler_q <= prescaler_d;
         index_q     <= index_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
         fd_q        <= fd_d;
      end
   end

   assign seg_out    = seg_q;
   assign an_out     = an_q;
   assign frame_done = fd_q;

endmodule

`default_nettype wire

// File: tb/tb_display_scan.sv
// ============================================================================
//  tb_display_scan
//  Directed scoreboard bench for display_scan (DIV = 10, BLANK_CYC = 2).
//  Honours DISPLAY_SCAN_LZB_EN for the expected leading-zero patterns.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_display_scan;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] bcd_in;
   logic        load;
   logic        overflow_in;
   logic [7:0]  seg_out;
   logic [5:0]  an_out;
   logic        frame_done;

   always #5 clk = ~clk;

   display_scan #(
      .CLK_HZ     (1000),
      .REFRESH_HZ (100),
      .BLANK_CYC  (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bcd_in      (bcd_in),
      .load        (load),
      .overflow_in (overflow_in),
      .seg_out     (seg_out),
      .an_out      (an_out),
      .frame_done  (frame_done)
   );

   typedef struct packed {
      logic [5:0] an;
      logic [7:0] seg;
   } slot_t;

   slot_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   function automatic logic [7:0] digit_pattern(input logic [3:0] d);
      case (d)
         4'd0: return 8'h03;
         4'd1: return 8'h9F;
         4'd2: return 8'h25;
         4'd3: return 8'h0D;
         4'd4: return 8'h99;
         4'd5: return 8'h49;
         4'd6: return 8'h41;
         4'd7: return 8'h1F;
         4'd8: return 8'h01;
         4'd9: return 8'h09;
         default: return 8'hFD;
      endcase
   endfunction

   function automatic logic [7:0] exp_seg(input logic [23:0] v, input logic ovf, input int slot);
      logic [3:0] d;
      d = 4'(v >> (4*(5-slot)));
      if (ovf) return 8'hFD;
`ifdef DISPLAY_SCAN_LZB_EN
      if (slot < 5 && (v >> (4*(5-slot))) == 24'h0) return 8'hFF;
`endif
      return digit_pattern(d);
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push_frame(input logic [23:0] v, input logic ovf);
      slot_t e;
      for (int s = 0; s < 6; s++) begin
         e.an  = ~(6'd1 << s);
         e.seg = exp_seg(v, ovf, s);
         exp_q.push_back(e);
      end
   endtask

   // Checks one 60-cycle frame; optional loads at frame cycles l1_n/l2_n and
   // a reset launched after cycle abort_n (-1 disables each).
   task automatic check_frame(input int l1_n, input logic [23:0] l1_v, input logic l1_o,
                              input int l2_n, input logic [23:0] l2_v, input logic l2_o,
                              input int abort_n);
      slot_t cur;
      cur = '{an: 6'h3F, seg: 8'hFF};
      for (int n = 1; n <= 60; n++) begin
         int s;
         int c;
         @(negedge clk);
         s = (n - 1) / 10;
         c = (n - 1) % 10;
         if (c == 0) begin
            checks++;
            assert (exp_q.size() > 0)
            else begin
               errors++;
               $error("FAIL scoreboard_underflow: observed size %0d expected >0", exp_q.size());
            end
            if (exp_q.size() > 0) cur = exp_q.pop_front();
         end
         if (c < 2)
            chk($sformatf("blank_s%0d_c%0d", s, c), 16'({an_out, seg_out}), 16'({6'h3F, 8'hFF}));
         else
            chk($sformatf("lit_s%0d_c%0d", s, c), 16'({an_out, seg_out}), 16'({cur.an, cur.seg}));
         chk($sformatf("frame_done_n%0d", n), 16'(frame_done), 16'(n == 60));
         if (n == abort_n) begin
            reset = 1'b1;
            load  = 1'b0;
            return;
         end
         load = 1'b0;
         if (n == l1_n) begin
            load = 1'b1; bcd_in = l1_v; overflow_in = l1_o;
         end
         if (n == l2_n) begin
            load = 1'b1; bcd_in = l2_v; overflow_in = l2_o;
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      load        = 1'b1;
      bcd_in      = 24'h654321;
      overflow_in = 1'b1;

      // Reset hold, with a load that must be ignored
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_idle", 16'({frame_done, an_out, seg_out}), 16'({1'b0, 6'h3F, 8'hFF}));
         if (i == 1) load = 1'b0;
      end
      reset       = 1'b0;
      overflow_in = 1'b0;

      push_frame(24'h000000, 1'b0);
      check_frame(-1, 24'h0, 1'b0, -1, 24'h0, 1'b0, -1);
      push_frame(24'h000000, 1'b0);
      check_frame(-1, 24'h0, 1'b0, -1, 24'h0, 1'b0, -1);

      // Scan order
      push_frame(24'h000000, 1'b0);
      check_frame(10, 24'h123456, 1'b0, -1, 24'h0, 1'b0, -1);

      // Double buffer: latest load wins
      push_frame(24'h123456, 1'b0);
      check_frame(5, 24'h111111, 1'b0, 20, 24'h222222, 1'b0, -1);

      // Load exactly on the boundary cycle
      push_frame(24'h222222, 1'b0);
      check_frame(59, 24'h000789, 1'b0, -1, 24'h0, 1'b0, -1);

      // Overflow
      push_frame(24'h000789, 1'b0);
      check_frame(30, 24'h123456, 1'b1, -1, 24'h0, 1'b0, -1);

      // Invalid BCD digit
      push_frame(24'h123456, 1'b1);
      check_frame(40, 24'h12A456, 1'b0, -1, 24'h0, 1'b0, -1);

      // Mid-frame reset with a pending value
      push_frame(24'h12A456, 1'b0);
      check_frame(5, 24'h999999, 1'b0, -1, 24'h0, 1'b0, 34);
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("midframe_reset_idle", 16'({frame_done, an_out, seg_out}), 16'({1'b0, 6'h3F, 8'hFF}));
      end
      reset = 1'b0;

      push_frame(24'h000000, 1'b0);
      check_frame(-1, 24'h0, 1'b0, -1, 24'h0, 1'b0, -1);
      push_frame(24'h000000, 1'b0);
      check_frame(-1, 24'h0, 1'b0, -1, 24'h0, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
